// File: rtl/mips_cpu_fetch.sv
// mips_cpu_fetch: single-outstanding instruction fetch stage for a MIPS core.
// Reads the word at pc over a wait-request bus, holds it in an instruction
// register until downstream consumes it, and locks up on a misaligned pc.
//
// Optional feature: define FETCH_BYTESWAP_EN to byte-reverse the bus word on
// capture (for a bus of the opposite endianness). Default build stores the
// bus word unchanged.
//
// Handshake summary: a bus read completes in a cycle where mem_read=1 and
// mem_waitrequest=0; address and strobe are held while waitrequest is high.
// Downstream consumes the held instruction with advance=1 while
// instr_valid=1; the PC stage must hold pc whenever stall=1.
module mips_cpu_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        stall,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        advance,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [5:0]  funct,
  output logic [15:0] offset,
  output logic [25:0] target,
  output logic        fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        pc_aligned;
  logic [31:0] capture_word;

  assign pc_aligned = (pc[1:0] == 2'b00);

`ifdef FETCH_BYTESWAP_EN
  assign capture_word = {mem_readdata[7:0], mem_readdata[15:8],
                         mem_readdata[23:16], mem_readdata[31:24]};
`else
  assign capture_word = mem_readdata;
`endif

  // Next-state and instruction-register load selection.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (!pc_aligned) begin
          state_d = FAULT;
        end else if (!mem_waitrequest) begin
          state_d = VALID;
          instr_d = capture_word;
        end
      end
      VALID: if (advance) state_d = REQ;
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // State and instruction register; reset abandons any read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Bus and pipeline outputs decoded from the registered state.
  assign mem_address = pc;
  assign mem_read    = (state_q == REQ) && pc_aligned;
  assign instr_valid = (state_q == VALID);
  assign stall       = (state_q != VALID);
  assign fault       = (state_q == FAULT);
  assign dbg_state   = state_q;

  // Fixed MIPS field slices of the stored instruction.
  assign instr  = instr_q;
  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign sa     = instr_q[10:6];
  assign funct  = instr_q[5:0];
  assign offset = instr_q[15:0];
  assign target = instr_q[25:0];

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// tb_mips_cpu_fetch: directed bench for mips_cpu_fetch. Expected instruction
// words are queued when a fetch is issued; a monitor pops one each time the
// DUT raises instr_valid.
module tb_mips_cpu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        stall;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        advance;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, sa;
  logic [5:0]  funct;
  logic [15:0] offset;
  logic [25:0] target;
  logic        fault;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        prev_valid = 1'b0;
  logic [31:0] held;

  mips_cpu_fetch dut (
    .clk(clk), .reset(reset), .pc(pc), .stall(stall),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .advance(advance), .instr_valid(instr_valid), .instr(instr),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .funct(funct),
    .offset(offset), .target(target), .fault(fault), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Driver helpers: inputs change 1ns after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Bus word that the DUT stores as the given instruction.
  function automatic logic [31:0] bus_word(input logic [31:0] w);
`ifdef FETCH_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Scoreboard monitor: each new instr_valid presentation pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got instr %h, expected no capture", instr);
        end else begin
          check("sb_instr", instr, exp_q.pop_front());
        end
      end
      prev_valid = instr_valid;
    end
  end

  initial begin
    reset = 1'b1;
    pc = 32'hBFC0_0000;
    mem_waitrequest = 1'b0;
    mem_readdata = bus_word(32'h2402_0005);
    advance = 1'b0;
    next_cycle();
    sample();
    // Reset values
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd1);
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);

    // Minimum-latency fetch at the reset vector
    next_cycle();
    reset = 1'b0;
    sample();
    check("idle_mem_read", {31'b0, mem_read}, 32'd0);
    exp_q.push_back(32'h2402_0005);
    sample();
    check("req_mem_read", {31'b0, mem_read}, 32'd1);
    check("req_addr", mem_address, 32'hBFC0_0000);
    check("req_stall", {31'b0, stall}, 32'd1);
    sample();
    check("v1_valid", {31'b0, instr_valid}, 32'd1);
    check("v1_opcode", {26'b0, opcode}, 32'h09);
    check("v1_rt", {27'b0, rt}, 32'h02);
    check("v1_offset", {16'b0, offset}, 32'h0005);
    check("v1_mem_read", {31'b0, mem_read}, 32'd0);

    // Hold in VALID while downstream is not ready
    held = instr;
    mem_readdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("hold_instr", instr, 32'h2402_0005);
      check("hold_stall", {31'b0, stall}, 32'd0);
      check("hold_mem_read", {31'b0, mem_read}, 32'd0);
    end

    // Advance; PC steps on the same edge; next fetch waits 3 cycles
    next_cycle();
    advance = 1'b1;
    next_cycle();
    advance = 1'b0;
    pc = 32'hBFC0_0004;
    mem_waitrequest = 1'b1;
    mem_readdata = bus_word(32'h0800_0010);
    exp_q.push_back(32'h0800_0010);
    for (int i = 0; i < 4; i++) begin
      sample();
      check("wait_mem_read", {31'b0, mem_read}, 32'd1);
      check("wait_addr", mem_address, 32'hBFC0_0004);
      check("wait_stall", {31'b0, stall}, 32'd1);
      check("wait_valid", {31'b0, instr_valid}, 32'd0);
      if (i == 2) begin
        next_cycle();
        mem_waitrequest = 1'b0;
      end
    end
    sample();
    check("v2_valid", {31'b0, instr_valid}, 32'd1);
    check("v2_opcode", {26'b0, opcode}, 32'h02);
    check("v2_target", {6'b0, target}, 32'h000_0010);

    // Misaligned pc goes to terminal FAULT
    next_cycle();
    advance = 1'b1;
    next_cycle();
    advance = 1'b0;
    pc = 32'hBFC0_0002;
    mem_readdata = 32'h1234_5678;
    sample();
    check("mis_mem_read", {31'b0, mem_read}, 32'd0);
    check("mis_fault_pre", {31'b0, fault}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      sample();
      check("flt_fault", {31'b0, fault}, 32'd1);
      check("flt_stall", {31'b0, stall}, 32'd1);
      check("flt_mem_read", {31'b0, mem_read}, 32'd0);
      check("flt_instr", instr, 32'h0800_0010);
      next_cycle();
      advance = ~advance;
    end
    advance = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("flt_rst_fault", {31'b0, fault}, 32'd0);
    check("flt_rst_instr", instr, 32'h0);

    // Reset between edges during a waiting read abandons it
    pc = 32'hBFC0_0000;
    mem_waitrequest = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    check("mid_mem_read", {31'b0, mem_read}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_stall", {31'b0, stall}, 32'd1);
    mem_waitrequest = 1'b0;
    mem_readdata = 32'hFFFF_FFFF;
    next_cycle();
    check("mid_no_capture", instr, 32'h0);

    // Fresh fetch after release uses the pc of the first REQ cycle (R-type)
    reset = 1'b0;
    pc = 32'h0000_0100;
    mem_readdata = bus_word(32'h012A_4020);
`ifdef FETCH_BYTESWAP_EN
    check("swap_bus_word", mem_readdata, 32'h2040_2A01);
`endif
    exp_q.push_back(32'h012A_4020);
    sample();
    sample();
    check("r_addr", mem_address, 32'h0000_0100);
    check("r_mem_read", {31'b0, mem_read}, 32'd1);
    sample();
    check("r_opcode", {26'b0, opcode}, 32'h00);
    check("r_rs", {27'b0, rs}, 32'd9);
    check("r_rt", {27'b0, rt}, 32'd10);
    check("r_rd", {27'b0, rd}, 32'd8);
    check("r_sa", {27'b0, sa}, 32'd0);
    check("r_funct", {26'b0, funct}, 32'h20);

`ifdef FETCH_BYTESWAP_EN
    // Byte-swapped capture of the literal bus word
    next_cycle();
    advance = 1'b1;
    next_cycle();
    advance = 1'b0;
    pc = 32'h0000_0104;
    mem_readdata = 32'h0500_0224;
    exp_q.push_back(32'h2402_0005);
    sample();
    sample();
    check("swap_instr", instr, 32'h2402_0005);
`endif

    sample();
    sample();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
